// File: rtl/bp_l2_dma_arbiter_if.sv
// Bundles the per-slice cache DMA ports and the single DRAM DMA port of bp_l2_dma_arbiter.
// master = arbiter view, slave = slices plus DRAM controller.
interface bp_l2_dma_arbiter_if #(
    parameter int num_req_p     = 2,
    parameter int caddr_width_p = 28,
    parameter int fill_width_p  = 64
);
    localparam int pkt_width_lp = caddr_width_p + 1;

    // Handshakes: v/yumi transfers when yumi is high (yumi only while v); v/ready_and transfers when both are high.
    logic [num_req_p*pkt_width_lp-1:0] req_pkt_i;
    logic [num_req_p-1:0]              req_pkt_v_i;
    logic [num_req_p-1:0]              req_pkt_yumi_o;
    logic [fill_width_p-1:0]           req_data_o;
    logic [num_req_p-1:0]              req_data_v_o;
    logic [num_req_p-1:0]              req_data_ready_and_i;
    logic [num_req_p*fill_width_p-1:0] req_data_i;
    logic [num_req_p-1:0]              req_data_v_i;
    logic [num_req_p-1:0]              req_data_yumi_o;
    logic [pkt_width_lp-1:0]           dma_pkt_o;
    logic                              dma_pkt_v_o;
    logic                              dma_pkt_yumi_i;
    logic [fill_width_p-1:0]           dma_data_i;
    logic                              dma_data_v_i;
    logic                              dma_data_ready_and_o;
    logic [fill_width_p-1:0]           dma_data_o;
    logic                              dma_data_v_o;
    logic                              dma_data_yumi_i;

    modport master (
        input  req_pkt_i, req_pkt_v_i, req_data_ready_and_i, req_data_i, req_data_v_i,
        input  dma_pkt_yumi_i, dma_data_i, dma_data_v_i, dma_data_yumi_i,
        output req_pkt_yumi_o, req_data_o, req_data_v_o, req_data_yumi_o,
        output dma_pkt_o, dma_pkt_v_o, dma_data_ready_and_o, dma_data_o, dma_data_v_o
    );

    modport slave (
        output req_pkt_i, req_pkt_v_i, req_data_ready_and_i, req_data_i, req_data_v_i,
        output dma_pkt_yumi_i, dma_data_i, dma_data_v_i, dma_data_yumi_i,
        input  req_pkt_yumi_o, req_data_o, req_data_v_o, req_data_yumi_o,
        input  dma_pkt_o, dma_pkt_v_o, dma_data_ready_and_o, dma_data_o, dma_data_v_o
    );
endinterface

// File: rtl/bp_l2_dma_arbiter.sv
// Round-robin arbiter sharing one DRAM DMA channel among L2 slices, one packet+block at a time.
// Optional busy-cycle counter enabled by `define BP_L2_DMA_ARB_PERF_EN.
module bp_l2_dma_arbiter #(
    parameter int num_req_p     = 2,
    parameter int caddr_width_p = 28,
    parameter int fill_width_p  = 64,
    parameter int block_beats_p = 8
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    bp_l2_dma_arbiter_if.master io,
    output logic [31:0]         busy_cycles_o,
    output logic [1:0]          state_o
);
    localparam int pkt_width_lp = caddr_width_p + 1;
    localparam int lg_req_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int lg_beats_lp  = $clog2(block_beats_p);
    localparam logic [lg_req_lp-1:0] last_req_lp = lg_req_lp'(num_req_p - 1);

    localparam logic [1:0] e_idle  = 2'd0;
    localparam logic [1:0] e_read  = 2'd1;
    localparam logic [1:0] e_write = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [lg_req_lp-1:0]    grant_q, grant_d;
    logic [lg_req_lp-1:0]    rr_ptr_q, rr_ptr_d;
    logic [lg_beats_lp-1:0]  beat_cnt_q, beat_cnt_d;
    logic [lg_req_lp-1:0]    pick;
    logic                    pick_found;
    logic [pkt_width_lp-1:0] pick_pkt;
    logic                    beat_fire;
    logic                    beat_last;

    // First valid slice scanning upward from rr_ptr_q with wrap.
    always_comb begin : rr_pick
        int                   idx;
        logic [lg_req_lp-1:0] cand;
        idx        = 0;
        cand       = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= num_req_p) idx = idx - num_req_p;
            cand = idx[lg_req_lp-1:0];
            if (!pick_found && io.req_pkt_v_i[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    assign pick_pkt  = io.req_pkt_i[int'(pick)*pkt_width_lp +: pkt_width_lp];
    assign beat_last = (beat_cnt_q == {lg_beats_lp{1'b1}});

    always_comb begin
        beat_fire = 1'b0;
        case (state_q)
            e_read:  beat_fire = io.dma_data_v_i & io.req_data_ready_and_i[grant_q];
            e_write: beat_fire = io.dma_data_yumi_i;
            default: beat_fire = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            e_idle: begin
                if (pick_found && io.dma_pkt_yumi_i) begin
                    grant_d    = pick;
                    rr_ptr_d   = (pick == last_req_lp) ? '0 : pick + 1'b1;
                    beat_cnt_d = '0;
                    state_d    = pick_pkt[caddr_width_p] ? e_write : e_read;
                end
            end
            e_read, e_write: begin
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_last) state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_idle;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Handshake outputs are gated by reset so they drop the moment reset asserts.
    always_comb begin
        io.req_pkt_yumi_o       = '0;
        io.req_data_o           = io.dma_data_i;
        io.req_data_v_o         = '0;
        io.req_data_yumi_o      = '0;
        io.dma_pkt_o            = pick_pkt;
        io.dma_pkt_v_o          = 1'b0;
        io.dma_data_ready_and_o = 1'b0;
        io.dma_data_o           = '0;
        io.dma_data_v_o         = 1'b0;
        if (reset_n_i) begin
            case (state_q)
                e_idle: begin
                    io.dma_pkt_v_o = pick_found;
                    if (pick_found && io.dma_pkt_yumi_i) io.req_pkt_yumi_o[pick] = 1'b1;
                end
                e_read: begin
                    io.req_data_v_o[grant_q] = io.dma_data_v_i;
                    io.dma_data_ready_and_o  = io.req_data_ready_and_i[grant_q];
                end
                e_write: begin
                    io.dma_data_o               = io.req_data_i[int'(grant_q)*fill_width_p +: fill_width_p];
                    io.dma_data_v_o             = io.req_data_v_i[grant_q];
                    io.req_data_yumi_o[grant_q] = io.dma_data_yumi_i;
                end
                default: ;
            endcase
        end
    end

`ifdef BP_L2_DMA_ARB_PERF_EN
    logic [31:0] busy_q;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) busy_q <= '0;
        else if (state_q != e_idle && busy_q != 32'hFFFF_FFFF) busy_q <= busy_q + 32'd1;
    end
    assign busy_cycles_o = busy_q;
`else
    assign busy_cycles_o = '0;
`endif

    assign state_o = state_q;
endmodule
